hamming_encoder: RTL and testbench

//  Streaming Hamming(12,8) encoder on the transmit side of the transceiver; pairs with hamming_decoder.

---
 rtl/hamming_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/hamming_encoder.sv | 63 ++++++
 tb/tb_hamming_encoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) constants and parity function, common to encoder and decoder.
package hamming_pkg;

  localparam int CW_W   = 12;
  localparam int DATA_W = 8;
  localparam int INJ_W  = 4;

  // Parity bits sit at the power-of-two 1-based positions 1, 2, 4 and 8.
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int P4_POS = 3;
  localparam int P8_POS = 7;

  // Codeword index that holds d[i].
  localparam int D_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

  function automatic logic [CW_W-1:0] hamming_parity(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] hc;
    hc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      hc[D_POS[i]] = d[i];
    end
    hc[P1_POS] = d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
    hc[P2_POS] = d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
    hc[P4_POS] = d[7] ^ d[3] ^ d[2] ^ d[1];
    hc[P8_POS] = d[7] ^ d[6] ^ d[5] ^ d[4];
    return hc;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered pointers/count and a registered write-ready.
// Write-ready looks at the next count, so a full FIFO stays closed for the cycle it is popped.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             wr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             full;
  logic             push;
  logic             pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + (AW+1)'(1);
    end else if (pop && !push) begin
      count_next = count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_ready <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_next;
      wr_ready <= (count_next < FULL_CNT);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/hamming_encoder.sv
// Streaming Hamming(12,8) encoder: parity, optional single-bit error injection, codeword FIFO.
// Codeword visible the cycle after its byte is accepted; s_ready drops once the FIFO fills.
module hamming_encoder
  import hamming_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              inj_en,
  input  logic [INJ_W-1:0]  inj_pos,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CW_W-1:0]   m_data,
  output logic [CNT_W-1:0]  word_cnt
);

  logic            push;
  logic            fifo_empty;
  logic [CW_W-1:0] inj_mask;
  logic [CW_W-1:0] cw;

  assign push = s_valid & s_ready;

  // Positions 12..15 match no codeword bit, so they leave the word untouched.
  always_comb begin
    inj_mask = '0;
    for (int i = 0; i < CW_W; i++) begin
      inj_mask[i] = inj_en && (inj_pos == INJ_W'(i));
    end
  end

  assign cw = hamming_parity(s_data) ^ inj_mask;

  sync_fifo #(
    .WIDTH (CW_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .arstn    (arstn),
    .wr_en    (push),
    .wr_data  (cw),
    .rd_en    (m_ready),
    .rd_data  (m_data),
    .empty    (fifo_empty),
    .wr_ready (s_ready)
  );

  assign m_valid = ~fifo_empty;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      word_cnt <= '0;
    end else if (push) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_encoder.sv
// Directed and random bench for hamming_encoder against a queue-based positional Hamming model.
module tb_hamming_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             arstn;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             inj_en;
  logic [3:0]       inj_pos;
  logic             m_valid;
  logic             m_ready;
  logic [11:0]      m_data;
  logic [CNT_W-1:0] word_cnt;

  int checks;
  int failures;

  logic [11:0]      q[$];
  logic             rdy_m;
  logic [CNT_W-1:0] wc_m;

  hamming_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .arstn    (arstn),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .inj_en   (inj_en),
    .inj_pos  (inj_pos),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Classic Hamming layout: data fills non-power-of-two positions in order,
  // parity at position 2^k covers every position whose index has bit k set.
  function automatic logic [11:0] enc(input logic [7:0] d);
    logic [11:0] c;
    int k;
    int pp;
    logic x;
    c = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      pp = 1 << b;
      x = 1'b0;
      for (int p = 1; p <= 12; p++) begin
        if (((p & pp) != 0) && (p != pp)) x = x ^ c[p-1];
      end
      c[pp-1] = x;
    end
    return c;
  endfunction

  // Single-error correction as the decoder does it: syndrome names the bad position.
  function automatic logic [7:0] dec(input logic [11:0] c_in);
    logic [11:0] c;
    int syn;
    int k;
    logic [7:0] d;
    c = c_in;
    syn = 0;
    for (int p = 1; p <= 12; p++) begin
      if (c[p-1]) syn = syn ^ p;
    end
    if (syn >= 1 && syn <= 12) c[syn-1] = ~c[syn-1];
    d = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive inputs, advance the model over the coming
  // rising edge, then check DUT outputs at the following negedge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r,
                     input logic ie, input logic [3:0] ip);
    logic push;
    logic pop;
    logic [11:0] cw;
    s_valid = v;
    s_data  = d;
    m_ready = r;
    inj_en  = ie;
    inj_pos = ip;
    push = v && rdy_m;
    pop  = r && (q.size() != 0);
    if (pop) void'(q.pop_front());
    if (push) begin
      cw = enc(d);
      if (ie && ip < 4'd12) cw[ip] = ~cw[ip];
      q.push_back(cw);
      wc_m = wc_m + 1'b1;
    end
    rdy_m = (q.size() < DEPTH);
    @(negedge clk);
    check("s_ready", 32'(s_ready), 32'(rdy_m));
    check("m_valid", 32'(m_valid), 32'(q.size() != 0));
    check("word_cnt", 32'(word_cnt), 32'(wc_m));
    if (q.size() != 0) check("m_data", 32'(m_data), 32'(q[0]));
  endtask

  task automatic idle(input logic r);
    cyc(1'b0, 8'h00, r, 1'b0, 4'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    q.delete();
    rdy_m = 1'b0;
    wc_m  = '0;
    arstn   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    inj_en  = 1'b0;
    inj_pos = '0;
    m_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    arstn = 1'b1;
    idle(1'b0);
    check("s_ready_after_release", 32'(s_ready), 32'd1);

    // 0x00 encodes to all zeros and is visible for exactly one cycle.
    cyc(1'b1, 8'h00, 1'b1, 1'b0, 4'd0);
    check("zero_cw", 32'(m_data), 32'h000);
    check("zero_cnt", 32'(word_cnt), 32'd1);
    idle(1'b1);
    check("zero_one_cycle", 32'(m_valid), 32'd0);

    // Back-to-back with sink always ready.
    cyc(1'b1, 8'hFF, 1'b1, 1'b0, 4'd0);
    check("cw_ff", 32'(m_data), 32'hF77);
    cyc(1'b1, 8'hA5, 1'b1, 1'b0, 4'd0);
    check("cw_a5", 32'(m_data), 32'hA27);
    idle(1'b1);

    // Injection on bit 6, then an out-of-range position.
    cyc(1'b1, 8'hA5, 1'b0, 1'b1, 4'd6);
    check("inj6_cw", 32'(m_data), 32'hA67);
    check("inj6_decoded", 32'(dec(m_data)), 32'hA5);
    idle(1'b1);
    cyc(1'b1, 8'hA5, 1'b0, 1'b1, 4'd13);
    check("inj13_cw", 32'(m_data), 32'hA27);
    idle(1'b1);
    // Injection with no push must not corrupt later words.
    cyc(1'b0, 8'h3C, 1'b1, 1'b1, 4'd2);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 4'd2);
    check("inj_no_push", 32'(m_data), 32'(enc(8'h3C)));
    idle(1'b1);

    // Fill with sink stalled; the DEPTH+1-th byte must bounce.
    for (int i = 0; i < DEPTH + 1; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 4'd0);
      if (i == DEPTH - 1) check("full_s_ready", 32'(s_ready), 32'd0);
    end
    check("full_cnt_no_extra", 32'(word_cnt), 32'(wc_m));
    check("hold_m_data", 32'(m_data), 32'(enc(8'h10)));
    idle(1'b1);
    check("ready_after_first_pop", 32'(s_ready), 32'd1);
    check("drain_order", 32'(m_data), 32'(enc(8'h11)));
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // Full with simultaneous push attempt and pop: only the pop happens.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 4'd0);
    check("full_pop_only_cnt", 32'(word_cnt), 32'(wc_m));
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // Random traffic with injection, checked every cycle against the queue model.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
    end

    // Async reset with words buffered.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 4'd0);
    #2;
    arstn = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_m_data", 32'(m_data), 32'd0);
    check("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    q.delete();
    rdy_m = 1'b0;
    wc_m  = '0;
    s_valid = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    idle(1'b1);
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
    check("post_rst_no_stale", 32'(m_valid), 32'd0);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, 4'd0);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
